// File: rtl/des_cfg_pkg.sv
// Shared constants for DES S-box reprogramming: FSM encoding, table geometry and
// the bit fields that split a flat entry index into {sbox, row, col}.
package des_cfg_pkg;

  localparam int N_SBOX           = 8;
  localparam int ENTRY_W          = 4;
  localparam int DEF_IDLE_TIMEOUT = 255;

  localparam int SBOX_ENTRIES = 64;
  localparam int ROWS         = 4;
  localparam int COLS         = 16;

  // Entry index layout, row-major: col in the low bits, then row, then sbox.
  localparam int COL_W    = $clog2(COLS);
  localparam int ROW_W    = $clog2(ROWS);
  localparam int SBOX_W   = $clog2(N_SBOX);
  localparam int COL_LSB  = 0;
  localparam int ROW_LSB  = COL_LSB + COL_W;
  localparam int SBOX_LSB = ROW_LSB + ROW_W;
  localparam int CNT_W    = SBOX_LSB + SBOX_W;

  localparam int TMO_W = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd1;
  localparam logic [1:0] ST_LOAD      = 2'd2;
  localparam logic [1:0] ST_FLUSH     = 2'd3;

endpackage

// File: rtl/sbox_cfg_ctrl.sv
// S-box table reprogramming sequencer: holds the DES core idle, then writes one table entry per beat.
// Latency: edit strobe one cycle after each accepted beat; done/err one cycle after the last FSM step.
// Backpressure: commands taken only in IDLE; entry beats taken only in LOAD, gaps stall without timeout.
module sbox_cfg_ctrl
  import des_cfg_pkg::*;
#(
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_all,
  input  logic [SBOX_W-1:0]  i_cmd_sbox,
  input  logic               i_dat_valid,
  output logic               o_dat_ready,
  input  logic [ENTRY_W-1:0] i_dat,
  input  logic               i_core_idle,
  input  logic               i_abort,
  output logic               o_hold_core,
  output logic               o_edit_sbox,
  output logic [SBOX_W-1:0]  o_sbox_sel,
  output logic [ROW_W-1:0]   o_row_sel,
  output logic [COL_W-1:0]   o_col_sel,
  output logic [ENTRY_W-1:0] o_new_val,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(SBOX_ENTRIES - 1);
  localparam logic [CNT_W-1:0] LAST_ALL = CNT_W'(N_SBOX * SBOX_ENTRIES - 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_all;
  logic [SBOX_W-1:0]  r_sbox;
  logic               r_cmd_rdy;
  logic               r_edit;
  logic [SBOX_W-1:0]  r_sbox_sel;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [ENTRY_W-1:0] r_val;
  logic               r_done;
  logic               r_err;

  logic       w_cmd_acc;
  logic       w_beat_acc;
  logic       w_last;
  logic       w_tmo_hit;
  logic [1:0] w_state_nxt;
  logic       w_done_nxt;
  logic       w_err_nxt;

  // cmd_ready is registered so it stays low while rst_n is asserted.
  assign w_cmd_acc  = r_cmd_rdy & i_cmd_valid;
  assign w_beat_acc = (r_state == ST_LOAD) & i_dat_valid & ~i_abort;
  assign w_last     = r_all ? (r_cnt == LAST_ALL) : (r_cnt == LAST_ONE);
  assign w_tmo_hit  = (r_tmo == TMO_W'(IDLE_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) w_state_nxt = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (i_abort || (!i_core_idle && w_tmo_hit)) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else if (i_core_idle) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_beat_acc && w_last) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_all      <= 1'b0;
      r_sbox     <= '0;
      r_cmd_rdy  <= 1'b0;
      r_edit     <= 1'b0;
      r_sbox_sel <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_val      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_rdy <= (w_state_nxt == ST_IDLE);
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_edit    <= w_beat_acc;
      if (w_cmd_acc) begin
        r_all  <= i_cmd_all;
        r_sbox <= i_cmd_sbox;
        r_cnt  <= '0;
        r_tmo  <= '0;
      end
      if ((r_state == ST_WAIT_IDLE) && !i_core_idle && !i_abort) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      // Edit bus fields only move on an accepted beat and hold otherwise.
      if (w_beat_acc) begin
        r_cnt      <= r_cnt + CNT_W'(1);
        r_sbox_sel <= r_all ? r_cnt[SBOX_LSB +: SBOX_W] : r_sbox;
        r_row      <= r_cnt[ROW_LSB +: ROW_W];
        r_col      <= r_cnt[COL_LSB +: COL_W];
        r_val      <= i_dat;
      end
    end
  end

  assign o_cmd_ready = r_cmd_rdy;
  assign o_dat_ready = (r_state == ST_LOAD);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_hold_core = (r_state != ST_IDLE);
  assign o_edit_sbox = r_edit;
  assign o_sbox_sel  = r_sbox_sel;
  assign o_row_sel   = r_row;
  assign o_col_sel   = r_col;
  assign o_new_val   = r_val;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_sbox_cfg_ctrl.sv
// Directed bench for sbox_cfg_ctrl: a scenario table plus hand sequences for timeout,
// idle abort and reset; a negedge monitor scores every edit strobe against the beat index.
module tb_sbox_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_cmd_valid, o_cmd_ready, i_cmd_all;
  logic [2:0] i_cmd_sbox;
  logic       i_dat_valid, o_dat_ready;
  logic [3:0] i_dat;
  logic       i_core_idle, i_abort;
  logic       o_hold_core, o_edit_sbox;
  logic [2:0] o_sbox_sel;
  logic [1:0] o_row_sel;
  logic [3:0] o_col_sel, o_new_val;
  logic       o_busy, o_done, o_err;
  logic [19:0] w_outs;

  sbox_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_all(i_cmd_all), .i_cmd_sbox(i_cmd_sbox),
    .i_dat_valid(i_dat_valid), .o_dat_ready(o_dat_ready), .i_dat(i_dat),
    .i_core_idle(i_core_idle), .i_abort(i_abort),
    .o_hold_core(o_hold_core), .o_edit_sbox(o_edit_sbox),
    .o_sbox_sel(o_sbox_sel), .o_row_sel(o_row_sel), .o_col_sel(o_col_sel),
    .o_new_val(o_new_val), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  assign w_outs = {o_cmd_ready, o_dat_ready, o_hold_core, o_edit_sbox, o_sbox_sel,
                   o_row_sel, o_col_sel, o_new_val, o_busy, o_done, o_err};

  always #5 clk = ~clk;

  typedef struct {
    int all; int sbox; int busy; int abort_at; int rst_at; int gaps; int seed;
    int exp_strobes; int exp_done; int exp_err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int strobe_n, done_n, err_n, done_cyc, last_strobe_cyc;
  int cur_all, cur_sbox, cur_seed;
  int acc_q[$];
  int exp_f, act_f, beat_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  // Every strobe k must carry entry k of the current command and lag its beat by one cycle.
  always @(negedge clk) begin
    if (o_dat_ready && i_dat_valid && !i_abort) acc_q.push_back(cyc);
    if (o_edit_sbox) begin
      exp_f = ((cur_all != 0 ? strobe_n / 64 : cur_sbox) << 10) | (((strobe_n / 16) % 4) << 8)
            | ((strobe_n % 16) << 4) | ((strobe_n + cur_seed) % 16);
      act_f = int'({o_sbox_sel, o_row_sel, o_col_sel, o_new_val});
      chk("edit_fields", act_f, exp_f);
      beat_c = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
      chk("strobe_lag", cyc - beat_c, 1);
      strobe_n++;
      last_strobe_cyc = cyc;
    end
    if (o_done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (o_err) err_n++;
    if (o_done || o_err) begin
      chk("pulse_exclusive", int'(o_done && o_err), 0);
      chk("busy_hold_at_pulse", int'({o_busy, o_hold_core}), 0);
    end
  end

  task automatic do_cmd(input int all, input int sbox);
    int n;
    n = 0;
    @(posedge clk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_all   = 1'(all);
    i_cmd_sbox  = 3'(sbox);
    at_sample();
    while (!o_cmd_ready && n < 20) begin
      @(posedge clk); at_sample(); n++;
    end
    chk("cmd_handshake", int'(o_cmd_ready), 1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    i_cmd_all   = ~i_cmd_all;
    i_cmd_sbox  = ~i_cmd_sbox;
  endtask

  task automatic run_vec(input vec_t v);
    int k, guard, total;
    bit stop, hit_rst, acc;
    cur_all = v.all; cur_sbox = v.sbox; cur_seed = v.seed;
    strobe_n = 0; done_n = 0; err_n = 0;
    acc_q.delete();
    total = (v.all != 0) ? 512 : 64;
    i_core_idle = (v.busy == 0);
    do_cmd(v.all, v.sbox);
    if (v.busy > 0) begin
      i_dat_valid = 1'b1;
      i_dat = 4'(v.seed % 16);
      for (int i = 0; i < v.busy; i++) begin
        at_sample();
        chk("wait_hold_noready", int'({o_hold_core, o_dat_ready, o_busy}), 5);
        @(posedge clk); #1;
      end
      chk("no_consume_in_wait", strobe_n + acc_q.size(), 0);
      i_core_idle = 1'b1;
    end
    k = 0; guard = 0; stop = 0; hit_rst = 0;
    while (!stop) begin
      if (k == v.rst_at) begin
        hit_rst = 1;
        break;
      end
      i_dat_valid = (v.gaps != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_dat = 4'((k + v.seed) % 16);
      i_abort = i_dat_valid && o_dat_ready && (k == v.abort_at);
      at_sample();
      acc = o_dat_ready && i_dat_valid;
      @(posedge clk); #1;
      if (acc && i_abort) stop = 1;
      else if (acc) begin
        k++;
        if (k >= total) stop = 1;
      end
      i_abort = 1'b0;
      guard++;
      if (guard > 4000) begin
        chk("beat_loop_timeout", k, total);
        stop = 1;
      end
    end
    i_dat_valid = 1'b0;
    i_abort = 1'b0;
    if (hit_rst) begin
      at_sample();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", int'(w_outs), 0);
      chk("rst_mid_strobes", strobe_n, v.exp_strobes);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      at_sample();
      chk("rst_release_busy", int'(o_busy), 0);
      @(posedge clk); at_sample();
      chk("rst_release_cmd_ready", int'(o_cmd_ready), 1);
      acc_q.delete();
      return;
    end
    for (int i = 0; i < 20; i++) begin
      at_sample();
      if (done_n + err_n != 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    at_sample();
    chk("strobe_count", strobe_n, v.exp_strobes);
    chk("done_count", done_n, v.exp_done);
    chk("err_count", err_n, v.exp_err);
    chk("end_cmd_ready", int'(o_cmd_ready), 1);
    chk("end_busy", int'(o_busy), 0);
    chk("pending_beats", acc_q.size(), 0);
    if (v.exp_done != 0 && v.exp_strobes > 0) chk("done_lag", done_cyc - last_strobe_cyc, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int hold_n, n, err_before;
    //           all sb busy abort rst gaps seed strobes done err
    vecs[0] = '{0, 3, 0,  -1, -1, 0, 0,  64,  1, 0};
    vecs[1] = '{0, 5, 10, -1, -1, 0, 7,  64,  1, 0};
    vecs[2] = '{0, 0, 0,  20, -1, 0, 0,  20,  0, 1};
    vecs[3] = '{1, 0, 0,  -1, -1, 1, 3,  512, 1, 0};
    vecs[4] = '{0, 7, 3,  -1, -1, 1, 9,  64,  1, 0};
    vecs[5] = '{0, 1, 0,  0,  -1, 0, 5,  0,   0, 1};
    vecs[6] = '{0, 6, 0,  63, -1, 1, 2,  63,  0, 1};
    vecs[7] = '{0, 2, 0,  -1, 30, 0, 4,  30,  0, 0};
    vecs[8] = '{0, 4, 0,  -1, -1, 0, 11, 64,  1, 0};

    rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_all = 1'b0; i_cmd_sbox = 3'd0;
    i_dat_valid = 1'b0; i_dat = 4'd0; i_core_idle = 1'b1; i_abort = 1'b0;
    strobe_n = 0; done_n = 0; err_n = 0; done_cyc = 0; last_strobe_cyc = 0;
    cur_all = 0; cur_sbox = 0; cur_seed = 0;
    #1;
    chk("reset_outputs", int'(w_outs), 0);
    #20;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); at_sample();
    chk("idle_cmd_ready", int'(o_cmd_ready), 1);
    chk("idle_busy_hold", int'({o_busy, o_hold_core, o_dat_ready}), 0);

    for (int v = 0; v < 9; v++) run_vec(vecs[v]);

    // Core never goes idle: 255 wait cycles, then error and back to IDLE.
    strobe_n = 0; done_n = 0; err_n = 0;
    i_core_idle = 1'b0;
    do_cmd(0, 2);
    hold_n = 0; n = 0;
    at_sample();
    while (err_n == 0 && n < 400) begin
      if (o_hold_core) hold_n++;
      @(posedge clk); at_sample(); n++;
    end
    chk("timeout_wait_cycles", hold_n, 255);
    chk("timeout_err", err_n, 1);
    chk("timeout_strobes", strobe_n, 0);
    chk("timeout_done", done_n, 0);
    @(posedge clk); at_sample();
    chk("timeout_cmd_ready_next", int'(o_cmd_ready), 1);
    i_core_idle = 1'b1;

    // Abort while idle is ignored.
    err_before = err_n;
    @(posedge clk); #1 i_abort = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_abort = 1'b0;
    at_sample();
    chk("idle_abort_err", err_n, err_before);
    chk("idle_abort_cmd_ready", int'(o_cmd_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sbox_cfg_ctrl.md
Name: sbox_cfg_ctrl

Overview:
Sequences run-time reprogramming of the eight DES S-box tables. It accepts a load command and a nibble stream from the host/config interface, and it holds off the DES round core until the core is idle. It then drives the shared S-box edit bus (edit strobe, sbox/row/col select, value) with one table entry per accepted beat. The block sits between the config interface and the eight S-box instances, plus the round controller's stall input.

Parameters:
N_SBOX, 8, number of S-boxes on the edit bus; sbox index width is 3.
ENTRY_W, 4, width of one S-box table entry.
IDLE_TIMEOUT, 255, maximum cycles spent waiting for i_core_idle before aborting with error (8-bit counter).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_cmd_valid  input  1  load command request
o_cmd_ready  output  1  command accepted when valid&ready
i_cmd_all  input  1  1 = load all 8 S-boxes (512 beats); 0 = single S-box (64 beats)
i_cmd_sbox  input  3  target S-box for single load; ignored when i_cmd_all=1
i_dat_valid  input  1  entry beat valid
o_dat_ready  output  1  entry beat accepted when valid&ready
i_dat  input  4  table entry value
i_core_idle  input  1  DES round core has no block in flight
i_abort  input  1  abort current operation
o_hold_core  output  1  round core must not start a new block
o_edit_sbox  output  1  edit strobe to S-boxes
o_sbox_sel  output  3  edit target S-box
o_row_sel  output  2  edit target row
o_col_sel  output  4  edit target column
o_new_val  output  4  edit value
o_busy  output  1  operation in progress
o_done  output  1  one-cycle pulse: load completed
o_err  output  1  one-cycle pulse: timeout or abort

Behaviour:
- Reset: state IDLE; all outputs 0; beat counter (9 bit) and timeout counter (8 bit) 0. Reset mid-load leaves the tables partially written. The S-boxes reset to the standard tables on the same rst_n.
- States: IDLE, WAIT_IDLE, LOAD, FLUSH.
- IDLE: o_cmd_ready=1. On cmd_valid: latch i_cmd_all/i_cmd_sbox, clear counters, go to WAIT_IDLE.
- WAIT_IDLE: o_hold_core=1. If i_core_idle, go to LOAD. Otherwise the timeout counter increments. When it reaches IDLE_TIMEOUT, pulse o_err and go to IDLE. i_abort has priority over i_core_idle: pulse o_err and go to IDLE.
- LOAD: o_dat_ready=1, o_hold_core=1. Each accepted beat writes entry number cnt.
  - Decoding: row=cnt[5:4], col=cnt[3:0], i.e. row-major, col 0..15 within row 0..3.
  - sbox = cnt[8:6] when all, else the latched i_cmd_sbox.
  - cnt increments per beat. Gaps in i_dat_valid are allowed with no timeout.
  - The final beat (cnt=63 single / 511 all) moves the block to FLUSH.
- Edit bus timing: registered. A beat accepted in cycle N produces o_edit_sbox=1 with the captured sel/row/col/value in cycle N+1, for exactly one cycle. The sel/row/col/value outputs hold their last values otherwise.
- FLUSH: one cycle, during which the final edit strobe is issued; then go to IDLE with o_done=1 for one cycle.
- o_busy=1 and o_hold_core=1 from the cycle after command acceptance through FLUSH. Both drop in the same cycle o_done (or o_err) pulses.
- i_abort in LOAD:
  - A beat accepted in the same cycle is discarded.
  - An edit already registered from the prior cycle still completes.
  - Then o_err pulses and the block returns to IDLE. Already-written entries remain.
- i_abort in IDLE or FLUSH is ignored. o_done and o_err never pulse together.
- o_dat_ready=0 outside LOAD. Beats presented then are not consumed.

Decomposition:
- Shared package des_cfg_pkg holds:
  - state encoding constants;
  - SBOX_ENTRIES=64, ROWS=4, COLS=16;
  - the entry-index-to-{sbox,row,col} field positions (reused by a future table readback block).
- No sub-module is needed. The timeout counter is inline.

Test Plan:
- Single load, core idle: cmd sbox=3, stream values 0..15 repeating with i_dat_valid held at 1. Expect 64 edit strobes starting 1 cycle after each beat, sbox_sel=3, first (row0,col0,val0), last (row3,col15,val15), and o_done exactly 1 cycle after the last strobe.
- Core busy: hold i_core_idle=0 for 10 cycles after the command. Expect o_hold_core=1 and o_dat_ready=0 for those cycles, then the load proceeds normally.
- Timeout: i_core_idle held at 0. Expect o_err pulse after 255 wait cycles, return to IDLE, zero edit strobes, o_cmd_ready=1 the next cycle.
- Abort: abort asserted on the same cycle as the 21st beat. Expect exactly 20 edit strobes (cols 0..15 of row0, cols 0..3 of row1), one o_err pulse, no o_done.
- Load all with random valid gaps: expect 512 strobes with sbox_sel stepping 0→7 every 64 writes, and o_done once.
- rst_n asserted mid-load (beat 30): all outputs 0 immediately; after release the block is in IDLE and accepts a new command.
